// File: rtl/sanity_if.sv
// Host/timer-side signals of the sanity timer arming controller.
// master: host and timer side; slave: the controller (sanity_ctrl).
interface sanity_if #(
    parameter int CNT_W = 4
);
    logic             csr_se;
    logic [2:0]       sw_sanity;
    logic             kick_tgl;
    logic             tmr_out;
    logic             tmr_ena;
    logic [2:0]       tmr_sanity;
    logic             kick_ack_tgl;
    logic             fired;
    logic [CNT_W-1:0] fire_cnt;

    modport master (
        output csr_se, sw_sanity, kick_tgl, tmr_out,
        input  tmr_ena, tmr_sanity, kick_ack_tgl, fired, fire_cnt
    );

    modport slave (
        input  csr_se, sw_sanity, kick_tgl, tmr_out,
        output tmr_ena, tmr_sanity, kick_ack_tgl, fired, fire_cnt
    );
endinterface

// File: rtl/sanity_ctrl.sv
// sanity_ctrl: arms, kicks and rearms the DELQA sanity timer in the sanity_clk domain.
// Optional macro SANITY_LOCK_EN: once armed, only rst can return the block to DIS.
module sanity_ctrl #(
    parameter int HOLDOFF = 2,
    parameter int CNT_W   = 4
) (
    input  logic    sanity_clk,
    input  logic    rst,
    sanity_if.slave bus
);
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        DIS    = 2'd0,
        ARM    = 2'd1,
        RELOAD = 2'd2,
        FIRED  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              se_m, se_s, kt_m, kt_s, to_m, to_s;
    logic [1:0]        blank, blank_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              tmr_ena, tmr_ena_nx;
    logic [2:0]        tmr_sanity, tmr_sanity_nx;
    logic              kick_ack_tgl, kick_ack_tgl_nx;
    logic              fired, fired_nx;
    logic [CNT_W-1:0]  fire_cnt, fire_cnt_nx;
    logic              kick_pend;
    logic              se_drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign kick_pend = (kt_s != kick_ack_tgl);

`ifdef SANITY_LOCK_EN
    assign se_drop = 1'b0;
`else
    assign se_drop = ~se_s;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_nx        = state;
        blank_nx        = blank;
        hold_nx         = hold;
        tmr_sanity_nx   = tmr_sanity;
        kick_ack_tgl_nx = kick_ack_tgl;
        fired_nx        = fired;
        fire_cnt_nx     = fire_cnt;

        case (state)
            DIS: begin
                tmr_sanity_nx = bus.sw_sanity;
                if (kick_pend) kick_ack_tgl_nx = kt_s;
                if (se_s) begin
                    state_nx = ARM;
                    blank_nx = 2'd2;
                end
            end
            ARM: begin
                // blank masks to_s left over from before the timer was enabled
                if (blank != 2'd0) blank_nx = blank - 2'd1;
                if (se_drop) begin
                    state_nx = DIS;
                end else if (kick_pend) begin
                    kick_ack_tgl_nx = kt_s;
                    state_nx        = RELOAD;
                end else if (blank == 2'd0 && !to_s) begin
                    state_nx    = FIRED;
                    fired_nx    = 1'b1;
                    fire_cnt_nx = sat_inc(fire_cnt);
                    hold_nx     = '0;
                end
            end
            RELOAD: begin
                if (se_drop) begin
                    state_nx = DIS;
                end else begin
                    state_nx = ARM;
                    blank_nx = 2'd2;
                end
            end
            FIRED: begin
                if (kick_pend) kick_ack_tgl_nx = kt_s;
                hold_nx = hold + HOLD_W'(1);
                if (se_drop) begin
                    state_nx = DIS;
                end else if (hold == HOLD_W'(HOLDOFF - 1)) begin
                    state_nx = RELOAD;
                end
            end
            default: state_nx = DIS;
        endcase

        if (state_nx == DIS) fired_nx = 1'b0;
        tmr_ena_nx = (state_nx == ARM) || (state_nx == FIRED);
    end

    // Synchronisers and state/output registers
    always_ff @(posedge sanity_clk) begin
        if (rst) begin
            se_m         <= 1'b0;
            se_s         <= 1'b0;
            kt_m         <= 1'b0;
            kt_s         <= 1'b0;
            to_m         <= 1'b0;
            to_s         <= 1'b0;
            state        <= DIS;
            blank        <= 2'd0;
            hold         <= '0;
            tmr_ena      <= 1'b0;
            tmr_sanity   <= 3'b000;
            kick_ack_tgl <= 1'b0;
            fired        <= 1'b0;
            fire_cnt     <= '0;
        end else begin
            se_m         <= bus.csr_se;
            se_s         <= se_m;
            kt_m         <= bus.kick_tgl;
            kt_s         <= kt_m;
            to_m         <= bus.tmr_out;
            to_s         <= to_m;
            state        <= state_nx;
            blank        <= blank_nx;
            hold         <= hold_nx;
            tmr_ena      <= tmr_ena_nx;
            tmr_sanity   <= tmr_sanity_nx;
            kick_ack_tgl <= kick_ack_tgl_nx;
            fired        <= fired_nx;
            fire_cnt     <= fire_cnt_nx;
        end
    end

    assign bus.tmr_ena      = tmr_ena;
    assign bus.tmr_sanity   = tmr_sanity;
    assign bus.kick_ack_tgl = kick_ack_tgl;
    assign bus.fired        = fired;
    assign bus.fire_cnt     = fire_cnt;
endmodule
